// File: rtl/dff_write_arbiter_pkg.sv
// Package dff_arb_pkg: shared definitions for the dff_write_arbiter slice.
//   state_t    - write sequencer states (IDLE -> GRANT -> COMMIT)
//   ptr_width  - number of bits needed to index NREQ requesters (minimum 1)
package dff_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Bits needed to hold an index in 0..n-1; a single requester still gets 1 bit.
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Interface dff_write_arbiter_if: bundle between the requesting blocks and the
// shared-register arbiter.
//   req   NREQ        per-requester write request (level, held until ack)
//   data  NREQ*WIDTH  requester i's data in data[i*WIDTH +: WIDTH]
//   clr   1           synchronous clear request (level)
//   gnt   NREQ        one-hot grant
//   ack   NREQ        one-hot one-cycle write-done pulse
//   busy  1           a write sequence is in progress
//   Q     WIDTH       shared register value
//   Q_n   WIDTH       complement of the shared register value
// Modports: master = requester side, slave = arbiter side.
interface dff_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [WIDTH-1:0]      Q;
  logic [WIDTH-1:0]      Q_n;

  modport master (
    output req, data, clr,
    input  gnt, ack, busy, Q, Q_n
  );

  modport slave (
    input  req, data, clr,
    output gnt, ack, busy, Q, Q_n
  );

endinterface

// File: rtl/dff_write_arbiter_rr_priority_pick.sv
// Module rr_priority_pick: combinational rotating priority encoder.
//   req  in   NREQ  request vector
//   ptr  in   PW    index with highest priority this round
//   any  out  1     at least one request is set
//   idx  out  PW    first set request scanning ptr, ptr+1, ... wrapping mod NREQ
module rr_priority_pick
  import dff_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;

  // Walk the offsets from ptr; the first hit (smallest offset) wins.
  always_comb begin
    any    = 1'b0;
    idx    = {PW{1'b0}};
    sum_s  = {(PW+1){1'b0}};
    cand_s = {PW{1'b0}};
    for (int off = 0; off < NREQ; off++) begin
      sum_s  = {1'b0, ptr} + (PW+1)'(off);
      // ptr < NREQ and off < NREQ, so one subtraction is enough to wrap.
      cand_s = (sum_s >= (PW+1)'(NREQ)) ? PW'(sum_s - (PW+1)'(NREQ)) : PW'(sum_s);
      idx    = (!any && req[cand_s]) ? cand_s : idx;
      any    = any | req[cand_s];
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Module dff_write_arbiter: round-robin arbiter owning one shared WIDTH-bit
// D-register with true (Q) and complement (Q_n) outputs. Each write runs
// IDLE -> GRANT -> COMMIT and returns a one-cycle ack to the winner.
//   CLK    in  clock, rising edge
//   RST_n  in  asynchronous active-low reset
//   bus    slave modport of dff_write_arbiter_if (req/data/clr in,
//          gnt/ack/busy/Q/Q_n out, all outputs registered)
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                CLK,
  input logic                RST_n,
  dff_write_arbiter_if.slave bus
);

  localparam int PW = ptr_width(NREQ);

  state_t           state_r;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    idx_r;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  ack_r;
  logic             busy_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_n_r;

  logic             pick_any_s;
  logic [PW-1:0]    pick_idx_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [PW-1:0]    ptr_next_s;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    return NREQ'(1'b1) << i;
  endfunction

  rr_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Only the latched winner's data is ever written.
  assign wr_data_s  = bus.data[int'(idx_r)*WIDTH +: WIDTH];
  // After a completed write the requester just served drops to lowest priority.
  assign ptr_next_s = (idx_r == PW'(NREQ-1)) ? {PW{1'b0}} : idx_r + PW'(1'b1);

  assign bus.gnt  = gnt_r;
  assign bus.ack  = ack_r;
  assign bus.busy = busy_r;
  assign bus.Q    = q_r;
  assign bus.Q_n  = q_n_r;

  // Write sequencer, arbitration pointer and the shared Q/Q_n register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= S_IDLE;
      ptr_r   <= {PW{1'b0}};
      idx_r   <= {PW{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      ack_r   <= {NREQ{1'b0}};
      busy_r  <= 1'b0;
      q_r     <= {WIDTH{1'b0}};
      q_n_r   <= {WIDTH{1'b1}};
    end else begin
      case (state_r)
        S_IDLE: begin
          ack_r <= {NREQ{1'b0}};
          if (bus.clr) begin
            // Clear wins over any pending request.
            q_r    <= {WIDTH{1'b0}};
            q_n_r  <= {WIDTH{1'b1}};
            gnt_r  <= {NREQ{1'b0}};
            busy_r <= 1'b0;
          end else if (pick_any_s) begin
            idx_r   <= pick_idx_s;
            gnt_r   <= onehot(pick_idx_s);
            busy_r  <= 1'b1;
            state_r <= S_GRANT;
          end else begin
            gnt_r  <= {NREQ{1'b0}};
            busy_r <= 1'b0;
          end
        end
        S_GRANT: begin
          gnt_r <= {NREQ{1'b0}};
          if (bus.req[idx_r]) begin
            q_r     <= wr_data_s;
            q_n_r   <= ~wr_data_s;
            ack_r   <= onehot(idx_r);
            state_r <= S_COMMIT;
          end else begin
            // Request withdrawn: abort without touching ptr or the register.
            ack_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_COMMIT: begin
          ptr_r   <= ptr_next_s;
          gnt_r   <= {NREQ{1'b0}};
          ack_r   <= {NREQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          gnt_r   <= {NREQ{1'b0}};
          ack_r   <= {NREQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Testbench for dff_write_arbiter: directed scenarios plus a long random run,
// all checked against a transaction-level reference model of the arbiter.
module tb_dff_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  dff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the register (-1 = nobody), how far along the
  // owner's write is (1 = granted, 2 = written/acked), whose turn is first,
  // and the stored value.
  int         m_ptr;
  int         m_owner;
  int         m_phase;
  logic [7:0] m_q;

  task automatic mdl_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_phase = 0;
    m_q     = 8'h00;
  endtask

  function automatic int mdl_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic mdl_edge();
    int w;
    logic [31:0] sh;
    if (m_owner < 0) begin
      if (bus.clr) begin
        m_q = 8'h00;
      end else begin
        w = mdl_pick(bus.req, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (bus.req[m_owner[1:0]]) begin
        sh      = bus.data >> (m_owner * WIDTH);
        m_q     = sh[7:0];
        m_phase = 2;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end
  endtask

  // Expected {gnt, ack, busy, Q, Q_n}.
  function automatic logic [24:0] mdl_vec();
    logic [3:0] g;
    logic [3:0] a;
    logic       b;
    g = 4'b0000;
    a = 4'b0000;
    b = 1'b0;
    if (m_owner >= 0) begin
      b = 1'b1;
      if (m_phase == 1) g = 4'b0001 << m_owner;
      else              a = 4'b0001 << m_owner;
    end
    return {g, a, b, m_q, ~m_q};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.gnt, bus.ack, bus.busy, bus.Q, bus.Q_n};
  endfunction

  // One clock: model follows the edge, outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) mdl_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    bus.req  = 4'b0000;
    bus.clr  = 1'b0;
    bus.data = 32'h0000_0000;
    mdl_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {4'h0, 4'h0, 1'b0, 8'h00, 8'hFF})
      $display("FAIL reset_initial got %h want %h", dut_vec(), {4'h0, 4'h0, 1'b0, 8'h00, 8'hFF});
    if (dut_vec() !== {4'h0, 4'h0, 1'b0, 8'h00, 8'hFF}) errors++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req  = 4'b0001;
    bus.data = 32'($urandom());
    tick();
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL reset_pre_grant got %h want %h", dut_vec(), mdl_vec());
    end
    // Reset in the middle of GRANT, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {4'h0, 4'h0, 1'b0, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_mid_grant got %h want %h", dut_vec(), {4'h0, 4'h0, 1'b0, 8'h00, 8'hFF});
    end
    mdl_reset();
    bus.req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++;
      $display("FAIL reset_after_release got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_single_write();
    logic [3:0] eg [3] = '{4'b0001, 4'b0000, 4'b0000};
    logic [3:0] ea [3] = '{4'b0000, 4'b0001, 4'b0000};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    bus.data       = 32'($urandom());
    bus.data[7:0]  = 8'hA5;
    bus.req        = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.gnt !== eg[i] || bus.ack !== ea[i] || bus.busy !== eb[i]) begin
        errors++;
        $display("FAIL single_hs cyc%0d got gnt=%b ack=%b busy=%b want gnt=%b ack=%b busy=%b",
                 i, bus.gnt, bus.ack, bus.busy, eg[i], ea[i], eb[i]);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL single_model cyc%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i >= 1) begin
        checks++;
        if (bus.Q !== 8'hA5 || bus.Q_n !== 8'h5A) begin
          errors++;
          $display("FAIL single_q cyc%0d got Q=%h Q_n=%h want Q=a5 Q_n=5a", i, bus.Q, bus.Q_n);
        end
      end
      if (i == 1) bus.req = 4'b0000;
    end
  endtask

  // The previous single write by requester 0 leaves requester 1 first in line.
  task automatic test_fairness();
    int         w;
    logic [7:0] exp_q;
    logic [31:0] rd;
    bus.req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      rd       = 32'($urandom());
      bus.data = rd;
      w        = (1 + g) % NREQ;
      exp_q    = 8'(rd >> (w * WIDTH));
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
          errors++;
          $display("FAIL fair_model g%0d c%0d got %h want %h", g, c, dut_vec(), mdl_vec());
        end
        if (c == 0) begin
          checks++;
          if (bus.gnt !== (4'b0001 << w)) begin
            errors++;
            $display("FAIL fair_order g%0d got gnt=%b want %b", g, bus.gnt, 4'b0001 << w);
          end
        end
        if (c == 1) begin
          checks++;
          if (bus.Q !== exp_q || bus.ack !== (4'b0001 << w)) begin
            errors++;
            $display("FAIL fair_write g%0d got Q=%h ack=%b want Q=%h ack=%b",
                     g, bus.Q, bus.ack, exp_q, 4'b0001 << w);
          end
        end
      end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  // Pointer is at 1 here. A withdrawn grant must not move it.
  task automatic test_withdraw();
    logic [3:0] rq [8] = '{4'b0100, 4'b0000, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] eg [8] = '{4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] ea [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [7:0] q_before;
    q_before = bus.Q;
    for (int i = 0; i < 8; i++) begin
      bus.req  = rq[i];
      bus.data = 32'($urandom());
      tick();
      checks++;
      if (bus.gnt !== eg[i] || bus.ack !== ea[i]) begin
        errors++;
        $display("FAIL withdraw_hs step%0d got gnt=%b ack=%b want gnt=%b ack=%b",
                 i, bus.gnt, bus.ack, eg[i], ea[i]);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL withdraw_model step%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i == 1) begin
        checks++;
        if (bus.Q !== q_before || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL withdraw_noop got Q=%h busy=%b want Q=%h busy=0", bus.Q, bus.busy, q_before);
        end
      end
    end
  endtask

  // Pointer is at 0 here.
  task automatic test_clear();
    logic [3:0] rq [9] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic       cl [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] eg [9] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] ea [9] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic [7:0] d1;
    logic [7:0] eq [9];
    d1 = 8'($urandom_range(1, 255));
    eq = '{8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, d1, d1, 8'h00, 8'h00};
    bus.data       = 32'($urandom());
    bus.data[7:0]  = 8'h3C;
    bus.data[15:8] = d1;
    for (int i = 0; i < 9; i++) begin
      bus.req = rq[i];
      bus.clr = cl[i];
      tick();
      checks++;
      if (bus.gnt !== eg[i] || bus.ack !== ea[i]) begin
        errors++;
        $display("FAIL clear_hs step%0d got gnt=%b ack=%b want gnt=%b ack=%b",
                 i, bus.gnt, bus.ack, eg[i], ea[i]);
      end
      if (i > 0) begin
        checks++;
        if (bus.Q !== eq[i] || bus.Q_n !== ~eq[i]) begin
          errors++;
          $display("FAIL clear_q step%0d got Q=%h Q_n=%h want Q=%h Q_n=%h",
                   i, bus.Q, bus.Q_n, eq[i], ~eq[i]);
        end
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL clear_model step%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] prev_gnt;
    prev_gnt = bus.gnt;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom());
      bus.clr  = ($urandom_range(0, 15) == 0);
      bus.data = 32'($urandom());
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL rand_model n%0d got %h want %h", n, dut_vec(), mdl_vec());
      end
      checks++;
      if (bus.Q_n !== ~bus.Q) begin
        errors++;
        $display("FAIL rand_qn n%0d got Q=%h Q_n=%h want Q_n=%h", n, bus.Q, bus.Q_n, ~bus.Q);
      end
      checks++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.ack)) begin
        errors++;
        $display("FAIL rand_onehot n%0d got gnt=%b ack=%b want one-hot or zero", n, bus.gnt, bus.ack);
      end
      if (bus.ack !== 4'b0000) begin
        checks++;
        if (prev_gnt !== bus.ack) begin
          errors++;
          $display("FAIL rand_ack_after_gnt n%0d got prev_gnt=%b want %b", n, prev_gnt, bus.ack);
        end
      end
      prev_gnt = bus.gnt;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_withdraw();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
